fir_stream_ctrl: RTL

Stream controller and coefficient bank for the 9-tap FIR datapath.
- Converts an input valid/ready sample stream into the filter's free-running one-sample-per-clock input.
- Tags each issued slot and realigns the tag with the filter output after the fixed pipeline latency.
- Buffers outputs in a FIFO so the downstream consumer may apply backpressure, since the filter itself cannot stall.
- Owns the runtime-writable coefficient registers and sequences IDLE/RUN/FLUSH/DRAIN.

---
 rtl/fir_stream_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fir_stream_ctrl.sv
// rtl/fir_stream_ctrl.sv - stream controller, output tag realignment, output FIFO and coefficient bank for a 9-tap FIR
module fir_stream_ctrl #(
    parameter int DATA_W     = 16,
    parameter int NTAPS      = 9,
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    flush_req,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_addr,
    input  logic [DATA_W-1:0]       cfg_data,
    output logic                    cfg_busy,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    output logic [DATA_W-1:0]       fir_in,
    input  logic [DATA_W-1:0]       fir_out,
    output logic [NTAPS*DATA_W-1:0] coef,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic [1:0]              state,
    output logic                    flush_done
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(PIPE_LAT + 2);
    localparam int FW = $clog2(NTAPS);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(NTAPS - 2);
    localparam logic [NTAPS*DATA_W-1:0] COEF_RST = {
        16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
        16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
    logic [PIPE_LAT:0]       tag_q, tag_d;
    logic [DATA_W-1:0]       fir_in_q, fir_in_d;
    logic [NTAPS*DATA_W-1:0] coef_q;
    logic [DATA_W-1:0]       fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [CW-1:0]           fifo_cnt_q;
    logic [IW-1:0]           inflight;
    logic [31:0]             used;
    logic                    credit_ok;
    logic                    accept;
    logic                    slot_tag;
    logic                    push;
    logic                    pop;

    // tag_q[0] travels alongside fir_in; the tag leaving tag_q[PIPE_LAT] lines up with fir_out
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= PIPE_LAT; i++) begin
            inflight = inflight + IW'(tag_q[i]);
        end
    end

    assign used      = 32'(fifo_cnt_q) + 32'(inflight);
    assign credit_ok = (used + 32'(NTAPS) <= 32'(FIFO_DEPTH));
    assign s_ready   = (state_q == ST_RUN) && credit_ok && !flush_req;
    assign accept    = s_valid && s_ready;
    assign push      = tag_q[PIPE_LAT];
    assign pop       = m_valid && m_ready;

    // The flush_req cycle's own slot is the first tail slot, so the tail follows the last sample contiguously
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        slot_tag    = 1'b0;
        flush_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    slot_tag    = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = ST_FLUSH;
                end else begin
                    slot_tag = accept;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    slot_tag    = 1'b1;
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    flush_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fir_in_d = accept ? s_data : '0;
    assign tag_d    = {tag_q[PIPE_LAT-1:0], slot_tag};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            tag_q       <= '0;
            fir_in_q    <= '0;
            coef_q      <= COEF_RST;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tag_q       <= tag_d;
            fir_in_q    <= fir_in_d;
            if (cfg_we && (state_q == ST_IDLE) && (32'(cfg_addr) < 32'(NTAPS))) begin
                coef_q[32'(cfg_addr)*DATA_W +: DATA_W] <= cfg_data;
            end
            if (push) begin
                wptr_q <= (wptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= fir_out;
        end
    end

    assign state    = state_q;
    assign cfg_busy = (state_q != ST_IDLE);
    assign fir_in   = fir_in_q;
    assign coef     = coef_q;
    assign m_valid  = (fifo_cnt_q != '0);
    assign m_data   = fifo_mem_q[rptr_q];

endmodule
